// File: rtl/bram_pingpong_wr_if.sv
// Bus bundle for bram_pingpong_wr: sample stream, release/clear strobes and BRAM write port.
// With BRAM_FRAME_CNT_EN defined the bundle also carries frame_cnt and drop_cnt.
interface bram_pingpong_wr_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_BUF = 2,
  parameter int unsigned ADDR_W  = 32
) ();

  logic                  valid;
  logic                  sinc;
  logic [DATA_W-1:0]     data_i;
  logic                  rd_done;
  logic                  ovf_clr;
  logic [NUM_BUF-1:0]    en_o;
  logic [DATA_W/8-1:0]   wrt_en;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     datos_o;
  logic                  rdy_to_read;
  logic [1:0]            rdy_idx;
  logic                  overflow;
`ifdef BRAM_FRAME_CNT_EN
  logic [15:0]           frame_cnt;
  logic [15:0]           drop_cnt;
`endif

  // Producer/consumer side: drives the stream and handshakes, observes the write port.
  modport master (
    output valid, sinc, data_i, rd_done, ovf_clr,
    input  en_o, wrt_en, addr, datos_o, rdy_to_read, rdy_idx, overflow
`ifdef BRAM_FRAME_CNT_EN
    , input frame_cnt, drop_cnt
`endif
  );

  // Writer side.
  modport slave (
    input  valid, sinc, data_i, rd_done, ovf_clr,
    output en_o, wrt_en, addr, datos_o, rdy_to_read, rdy_idx, overflow
`ifdef BRAM_FRAME_CNT_EN
    , output frame_cnt, drop_cnt
`endif
  );

endinterface

// File: rtl/bram_pingpong_wr.sv
// Multi-bank capture writer: streams samples into NUM_BUF BRAM banks in strict rotation,
// pulses rdy_to_read when a bank fills and waits for rd_done releases (oldest bank first).
// Optional feature macro: BRAM_FRAME_CNT_EN adds frame_cnt and drop_cnt outputs.
module bram_pingpong_wr #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned NUM_BUF = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RESYNC  = 0
) (
  input logic               clk,
  input logic               rst_n,
  bram_pingpong_wr_if.slave bus
);

  localparam int unsigned BytesW = DATA_W / 8;
  localparam int unsigned IdxW   = $clog2(DEPTH);

  typedef enum logic [1:0] {StArmed, StWrite, StWaitFree} state_e;

  // State entered whenever a fresh bank becomes writable.
  localparam state_e ResumeSt = (RESYNC != 0) ? StArmed : StWrite;

  state_e              state_q, state_d;
  logic [1:0]          bank_q, bank_d;
  logic [1:0]          head_q, head_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [3:0]          full_q, full_d;
  logic [3:0]          bank_oh;
  logic                accept, drop;

  logic [NUM_BUF-1:0]  en_q, en_d;
  logic [BytesW-1:0]   wrt_q, wrt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rdy_q, rdy_d;
  logic [1:0]          rdy_idx_q, rdy_idx_d;
  logic                ovf_q, ovf_d;

  function automatic logic [1:0] bank_inc(input logic [1:0] b);
    return (b == 2'(NUM_BUF - 1)) ? 2'd0 : b + 2'd1;
  endfunction

  assign bank_oh = 4'b0001 << bank_q;

  // Next-state: release first, then write/drop decision, bank-full bookkeeping and output regs.
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    head_d    = head_q;
    idx_d     = idx_q;
    full_d    = full_q;
    en_d      = '0;
    wrt_d     = '0;
    addr_d    = addr_q;
    data_d    = data_q;
    rdy_d     = 1'b0;
    rdy_idx_d = rdy_idx_q;
    accept    = 1'b0;
    drop      = 1'b0;

    // Banks fill and release in the same rotation, so head_q is always the oldest full bank.
    if (bus.rd_done && (|full_q)) begin
      full_d[head_q] = 1'b0;
      head_d         = bank_inc(head_q);
    end

    unique case (state_q)
      StArmed: accept = bus.valid && bus.sinc;
      StWrite: accept = bus.valid;
      StWaitFree: begin
        // A sample arriving in the release cycle is still lost.
        drop = bus.valid;
        if (!full_d[bank_q]) state_d = ResumeSt;
      end
      default: state_d = StArmed;
    endcase

    if (accept) begin
      en_d   = bank_oh[NUM_BUF-1:0];
      wrt_d  = '1;
      addr_d = ADDR_W'(idx_q) * ADDR_W'(BytesW);
      data_d = bus.data_i;
      if (idx_q == IdxW'(DEPTH - 1)) begin
        full_d[bank_q] = 1'b1;
        rdy_d          = 1'b1;
        rdy_idx_d      = bank_q;
        idx_d          = '0;
        bank_d         = bank_inc(bank_q);
        state_d        = full_d[bank_d] ? StWaitFree : ResumeSt;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = StWrite;
      end
    end

    // Set wins over clear.
    ovf_d = drop | (ovf_q & ~bus.ovf_clr);
  end

  // State and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StArmed;
      bank_q    <= '0;
      head_q    <= '0;
      idx_q     <= '0;
      full_q    <= '0;
      en_q      <= '0;
      wrt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      rdy_idx_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      head_q    <= head_d;
      idx_q     <= idx_d;
      full_q    <= full_d;
      en_q      <= en_d;
      wrt_q     <= wrt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      rdy_idx_q <= rdy_idx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.en_o        = en_q;
  assign bus.wrt_en      = wrt_q;
  assign bus.addr        = addr_q;
  assign bus.datos_o     = data_q;
  assign bus.rdy_to_read = rdy_q;
  assign bus.rdy_idx     = rdy_idx_q;
  assign bus.overflow    = ovf_q;

`ifdef BRAM_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Frame counter wraps; drop counter saturates and restarts from this cycle's drop on clear.
  always_comb begin
    frame_cnt_d = rdy_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (bus.ovf_clr) begin
      drop_cnt_d = {15'd0, drop};
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: doc/bram_pingpong_wr.md
Name: bram_pingpong_wr

Overview:
- Parametrised multi-bank capture writer: streams valid samples into NUM_BUF BRAM banks in rotation.
- Produces per-bank port enables, byte write enable, byte address and data.
- Signals a completed bank with a one-cycle ready pulse.
- Sits between the receiver sample stream and the PS-readable BRAM banks.
- Adds bank-release handshake, start sync, per-bank resync and overflow detection.

Parameters:
- DATA_W, 32, sample/BRAM word width in bits; multiple of 8.
- DEPTH, 1024, words per bank; power of two, >= 4.
- NUM_BUF, 2, number of banks, 2..4.
- ADDR_W, 32, width of the byte address output.
- RESYNC, 0, 1 = every new bank waits for sinc; 0 = only the first bank after reset or re-arm.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid  input  1  data_i is a valid sample this cycle.
- sinc  input  1  start/sync strobe; sampled with valid.
- data_i  input  DATA_W  sample data.
- rd_done  input  1  one-cycle pulse: consumer releases the oldest full bank.
- ovf_clr  input  1  clears the overflow flag.
- en_o  output  NUM_BUF  per-bank enable, one-hot or zero.
- wrt_en  output  DATA_W/8  byte write enable.
- addr  output  ADDR_W  byte address within the bank = index*(DATA_W/8).
- datos_o  output  DATA_W  registered write data.
- rdy_to_read  output  1  one-cycle pulse when a bank fills.
- rdy_idx  output  2  bank index associated with the latest rdy_to_read.
- overflow  output  1  sticky: sample dropped because no bank was free.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0.
  - State ARMED, write bank 0, index 0.
  - All banks free; full-bank queue empty.
  - A reset mid-capture discards the partial bank and all full-bank state.
- Write port:
  - Registered: a sample accepted in cycle N drives en_o[bank]=1, wrt_en=all ones, addr and datos_o in cycle N+1.
  - Outside write cycles: en_o=0 and wrt_en=0; addr and datos_o hold.
- ARMED:
  - valid without sinc → ignored.
  - valid&sinc → sample written at index 0; go to WRITE.
- WRITE:
  - Each valid writes at the current index, then increments it; sinc is ignored.
  - On the write at index DEPTH-1:
    - current bank marked full and pushed to the full-bank queue (FIFO order);
    - rdy_to_read pulses in the same cycle as that write strobe (N+1); rdy_idx = that bank;
    - index wraps to 0 and the bank pointer advances modulo NUM_BUF.
  - Next state:
    - next bank free and RESYNC=0 → WRITE;
    - next bank free and RESYNC=1 → ARMED;
    - next bank not free → WAIT_FREE.
- WAIT_FREE:
  - Every valid is dropped and sets overflow.
  - When the awaited bank is freed by rd_done → ARMED (RESYNC=1) or WRITE (RESYNC=0).
  - If the bank is freed in the same cycle as a valid, that sample is still dropped.
- rd_done:
  - Frees the head of the full-bank queue.
  - Ignored when the queue is empty.
  - rd_done in the same cycle as a bank-full event: the release is processed first. When NUM_BUF=2 and the released bank is the next bank, capture continues in WRITE with no gap.
- overflow:
  - Set on any dropped sample; cleared by ovf_clr.
  - Set and clear in the same cycle → set wins.
- Banks are written strictly in rotation; a free but out-of-order bank is never used.

Optional Feature:
- BRAM_FRAME_CNT_EN defined:
  - Adds output frame_cnt [15:0], reset 0.
  - Increments on each rdy_to_read, wraps at 0xFFFF → 0.
  - Adds output drop_cnt [15:0], incremented per dropped sample, saturating at 0xFFFF, cleared by ovf_clr.
- Undefined: neither port exists and no counter logic is present.

Test Plan:
1. DEPTH=4, NUM_BUF=2, RESYNC=0; valid held high with data 1,2,3,… and sinc pulsed with sample 1 →
   - en_o=01 with addr 0,4,8,12 and data 1..4;
   - rdy_to_read pulses with the addr=12 write, rdy_idx=0;
   - then en_o=10 with data 5..8.
2. Valid high with sinc=0 for 10 cycles after reset → en_o stays 0 and overflow stays 0; the first valid&sinc sample is written to addr 0.
3. DEPTH=4, NUM_BUF=2, no rd_done; 12 consecutive valid samples →
   - both banks filled (rdy_idx 0 then 1);
   - samples 9..12 dropped, overflow=1, en_o=0;
   - rd_done then frees bank 0 and the next valid writes bank 0 at addr 0.
4. NUM_BUF=2; rd_done for bank 0 asserted in the same cycle as bank 1 fills → no WAIT_FREE, no drop; the next sample is written to bank 0 at addr 0.
5. RESYNC=1: after bank 0 fills, valid without sinc → ignored; valid&sinc → written to bank 1 at addr 0.
6. rst_n pulled low mid-bank at index 2 → all outputs 0 immediately; after release, the state is ARMED and the next valid&sinc writes bank 0 at addr 0. With BRAM_FRAME_CNT_EN defined, frame_cnt=0 after reset.
